dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 71 +++++++
 tb/tb_dmem_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/DMA arbiter for a single-port data memory with anti-starvation and 1-cycle read responses
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 1024,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          core_err,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);
  localparam logic [AW-1:0] TOP = AW'(DEPTH);
  typedef enum logic [1:0] {IDLE, RD_CORE, RD_DMA} state_t;
  state_t state;
  logic [CW-1:0] starve_cnt;
  logic force_dma, sel_we, in_range;
  // Grant decision and memory-port steering; all gated by reset
  always_comb begin
    force_dma = dma_req && starve_cnt == LIM;
    core_gnt = rst && core_req && !force_dma;
    dma_gnt = rst && dma_req && !core_gnt;
    core_stall = core_req && !core_gnt;
    sel_we = core_gnt ? core_we : dma_we;
    mem_addr = core_gnt ? core_addr : dma_addr;
    mem_wdata = core_gnt ? core_wdata : dma_wdata;
    in_range = mem_addr < TOP;
    mem_en = (core_gnt || dma_gnt) && in_range;
    mem_we = mem_en && sel_we;
  end
  // Response FSM, starvation counter and error pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      core_err <= 1'b0;
      dma_err <= 1'b0;
    end else begin
      state <= (mem_en && !sel_we) ? (core_gnt ? RD_CORE : RD_DMA) : IDLE;
      starve_cnt <= (!dma_req || dma_gnt) ? '0 : (core_gnt && starve_cnt != LIM) ? starve_cnt + 1'b1 : starve_cnt;
      core_err <= core_gnt && !in_range;
      dma_err <= dma_gnt && !in_range;
    end
  end
  assign core_rvalid = state == RD_CORE;
  assign dma_rvalid = state == RD_DMA;
  assign core_rdata = core_rvalid ? mem_rdata : '0;
  assign dma_rdata = dma_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;
  logic clk = 0, rst = 0;
  logic core_req = 0, core_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic core_gnt, core_stall, core_rvalid, core_err;
  logic dma_gnt, dma_rvalid, dma_err;
  logic [31:0] core_rdata, dma_rdata;
  logic mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [31:0] mem [1024];
  logic [31:0] gold [1024];
  logic [31:0] core_q[$], dma_q[$];
  int total = 0, bad = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears one cycle after a read strobe
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                      input bit ecg, input bit edg, input string tag);
    logic [31:0] a;
    bit w, inr;
    rst = r; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #2;
    chk({tag, " core_gnt"}, 32'(core_gnt), 32'(ecg));
    chk({tag, " dma_gnt"}, 32'(dma_gnt), 32'(edg));
    chk({tag, " core_stall"}, 32'(core_stall), 32'(cr && !ecg));
    a = ecg ? ca : da;
    w = ecg ? cw : dw;
    inr = (ecg || edg) && a < 32'd1024;
    chk({tag, " mem_en"}, 32'(mem_en), 32'(inr));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(inr && w));
    if (inr) chk({tag, " mem_addr"}, mem_addr, a);
    if (inr && w) chk({tag, " mem_wdata"}, mem_wdata, ecg ? cd : dd);
    if (inr && !w) begin
      if (ecg) core_q.push_back(gold[a[9:0]]);
      else dma_q.push_back(gold[a[9:0]]);
    end
    if (inr && w) gold[a[9:0]] = ecg ? cd : dd;
    @(posedge clk);
    #1;
    chk({tag, " core_err"}, 32'(core_err), 32'(ecg && ca >= 32'd1024));
    chk({tag, " dma_err"}, 32'(dma_err), 32'(edg && da >= 32'd1024));
    chk({tag, " core_rvalid"}, 32'(core_rvalid), 32'(core_q.size() != 0));
    chk({tag, " core_rdata"}, core_rdata, core_q.size() != 0 ? core_q.pop_front() : 32'h0);
    chk({tag, " dma_rvalid"}, 32'(dma_rvalid), 32'(dma_q.size() != 0));
    chk({tag, " dma_rdata"}, dma_rdata, dma_q.size() != 0 ? dma_q.pop_front() : 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) gold[i] = 32'h0;
    // reset with both requesters active: nothing granted, nothing strobed
    step(0, 1, 0, 28, 0, 1, 0, 248, 0, 0, 0, "rst0");
    step(0, 1, 1, 5, 7, 1, 1, 5, 7, 0, 0, "rst1");
    // preload through the DMA write path
    step(1, 0, 0, 0, 0, 1, 1, 0, 32'h00C0FFEE, 0, 1, "pre0");
    step(1, 0, 0, 0, 0, 1, 1, 27, 32'h000000F1, 0, 1, "pre27");
    step(1, 0, 0, 0, 0, 1, 1, 28, 32'h000000F0, 0, 1, "pre28");
    step(1, 0, 0, 0, 0, 1, 1, 248, 32'hF00000AC, 0, 1, "pre248");
    // single core read
    step(1, 1, 0, 28, 0, 0, 0, 0, 0, 1, 0, "crd28");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle0");
    // back-to-back core reads
    step(1, 1, 0, 27, 0, 0, 0, 0, 0, 1, 0, "b2b27");
    step(1, 1, 0, 248, 0, 0, 0, 0, 0, 1, 0, "b2b248");
    // lone DMA read granted immediately
    step(1, 0, 0, 0, 0, 1, 0, 248, 0, 0, 1, "drd248");
    // DMA write then core read of the same word
    step(1, 0, 0, 0, 0, 1, 1, 5, 32'hA5A5A5A5, 0, 1, "dwr5");
    step(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, "crd5");
    // out-of-range accesses
    step(1, 0, 0, 0, 0, 1, 1, 1024, 32'h12345678, 0, 1, "dwr1024");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "crd0");
    step(1, 1, 0, 2000, 0, 0, 0, 0, 0, 1, 0, "crd2000");
    step(1, 0, 0, 0, 0, 1, 0, 1023, 0, 0, 1, "drd1023");
    // contention: four core grants then one DMA grant, twice
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) step(1, 1, 0, 27, 0, 1, 0, 248, 0, 1, 0, "cont_core");
      step(1, 1, 0, 27, 0, 1, 0, 248, 0, 0, 1, "cont_dma");
    end
    // dropping dma_req clears the starvation count
    step(1, 1, 0, 28, 0, 1, 0, 248, 0, 1, 0, "clr_a");
    step(1, 1, 0, 28, 0, 1, 0, 248, 0, 1, 0, "clr_b");
    step(1, 1, 0, 28, 0, 0, 0, 0, 0, 1, 0, "clr_drop");
    for (int j = 0; j < 4; j++) step(1, 1, 0, 28, 0, 1, 0, 27, 0, 1, 0, "clr_core");
    step(1, 1, 0, 28, 0, 1, 0, 27, 0, 0, 1, "clr_dma");
    // reset during the response cycle of a read
    step(1, 1, 0, 248, 0, 0, 0, 0, 0, 1, 0, "mid_rd");
    step(0, 1, 0, 28, 0, 0, 0, 0, 0, 0, 0, "mid_rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst");
    step(1, 1, 0, 5, 0, 1, 0, 27, 0, 1, 0, "post_cg");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
